// File: rtl/ssd_instr_executor.sv
// Instruction executor at the tail of the dedup pipeline: expands ssd_instr_t into
// per-block SSD commands, tracks outstanding completions, returns one response per instruction.
`timescale 1ns/1ps

package common;
  localparam int LBA_WIDTH           = 32;
  localparam int HASH_WIDTH          = 256;
  localparam int NODE_IDX_WIDTH      = 16;
  localparam int DATA_NODE_IDX_WIDTH = 20;

  typedef enum logic [1:0] {
    WRITE        = 2'd0,
    ERASE        = 2'd1,
    READ         = 2'd2,
    UPDATEHEADER = 2'd3
  } ssd_op_t;

  typedef struct packed {
    ssd_op_t                        op_code;
    logic [NODE_IDX_WIDTH-1:0]      node_idx;
    logic [DATA_NODE_IDX_WIDTH-1:0] ssd_node_idx;
    logic [HASH_WIDTH-1:0]          sha3_hash;
    logic [LBA_WIDTH-1:0]           ssd_start;
    logic [LBA_WIDTH-1:0]           ssd_len;
    logic [LBA_WIDTH-1:0]           ref_count;
  } ssd_instr_t;
endpackage

module ssd_instr_executor #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int OCNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    instr_valid,
  output logic                                    instr_ready,
  input  logic [$bits(common::ssd_instr_t)-1:0]   instr,
  output logic                                    cmd_valid,
  input  logic                                    cmd_ready,
  output logic [1:0]                              cmd_op,
  output logic [common::LBA_WIDTH-1:0]            cmd_lba,
  output logic [common::DATA_NODE_IDX_WIDTH-1:0]  cmd_node_idx,
  output logic [common::HASH_WIDTH-1:0]           cmd_hash,
  output logic [common::LBA_WIDTH-1:0]            cmd_ref_count,
  output logic                                    cmd_last,
  input  logic                                    cmd_done,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [common::NODE_IDX_WIDTH-1:0]       rsp_node_idx,
  output logic [1:0]                              rsp_op,
  output logic [1:0]                              rsp_status,
  output logic [common::LBA_WIDTH-1:0]            rsp_count,
  output logic                                    err_spurious
);
  import common::*;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

  localparam logic [1:0]            ST_OK    = 2'd0;
  localparam logic [1:0]            ST_EMPTY = 2'd1;
  localparam logic [1:0]            ST_RANGE = 2'd2;
  localparam logic [OCNT_WIDTH-1:0] OCNT_MAX = OCNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [OCNT_WIDTH-1:0] OCNT_ONE = OCNT_WIDTH'(1'b1);
  localparam logic [LBA_WIDTH-1:0]  LBA_ONE  = LBA_WIDTH'(1'b1);

  state_t                         state_r;
  ssd_instr_t                     instr_s;
  logic [LBA_WIDTH-1:0]           n_r;
  logic [LBA_WIDTH-1:0]           idx_r;
  logic [LBA_WIDTH-1:0]           idx_inc_s;
  logic [OCNT_WIDTH-1:0]          ocnt_r;
  logic [OCNT_WIDTH-1:0]          ocnt_next_s;
  logic [LBA_WIDTH:0]             end_s;
  logic                           cmd_hs_s;
  logic                           spurious_s;
  logic                           is_data_s;
  logic                           len_zero_s;
  logic                           range_err_s;
  logic                           last_next_s;
  logic                           throttle_next_s;

  logic                           instr_ready_r;
  logic                           cmd_valid_r;
  logic [1:0]                     cmd_op_r;
  logic [LBA_WIDTH-1:0]           cmd_lba_r;
  logic [DATA_NODE_IDX_WIDTH-1:0] cmd_node_idx_r;
  logic [HASH_WIDTH-1:0]          cmd_hash_r;
  logic [LBA_WIDTH-1:0]           cmd_ref_count_r;
  logic                           cmd_last_r;
  logic                           rsp_valid_r;
  logic [NODE_IDX_WIDTH-1:0]      rsp_node_idx_r;
  logic [1:0]                     rsp_op_r;
  logic [1:0]                     rsp_status_r;
  logic [LBA_WIDTH-1:0]           rsp_count_r;
  logic                           err_spurious_r;

  assign instr_ready   = instr_ready_r;
  assign cmd_valid     = cmd_valid_r;
  assign cmd_op        = cmd_op_r;
  assign cmd_lba       = cmd_lba_r;
  assign cmd_node_idx  = cmd_node_idx_r;
  assign cmd_hash      = cmd_hash_r;
  assign cmd_ref_count = cmd_ref_count_r;
  assign cmd_last      = cmd_last_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_node_idx  = rsp_node_idx_r;
  assign rsp_op        = rsp_op_r;
  assign rsp_status    = rsp_status_r;
  assign rsp_count     = rsp_count_r;
  assign err_spurious  = err_spurious_r;

  // Instruction decode, range check and next outstanding count
  always_comb begin
    instr_s     = ssd_instr_t'(instr);
    cmd_hs_s    = cmd_valid_r & cmd_ready;
    is_data_s   = (instr_s.op_code != UPDATEHEADER);
    len_zero_s  = (instr_s.ssd_len == {LBA_WIDTH{1'b0}});
    // One extra bit so that start+len reaching exactly 2^LBA_WIDTH is still legal
    end_s       = {1'b0, instr_s.ssd_start} + {1'b0, instr_s.ssd_len};
    range_err_s = end_s[LBA_WIDTH] & (end_s[LBA_WIDTH-1:0] != {LBA_WIDTH{1'b0}});
    idx_inc_s   = idx_r + LBA_ONE;
    last_next_s = (idx_inc_s == (n_r - LBA_ONE));
    ocnt_next_s = ocnt_r;
    spurious_s  = 1'b0;
    if (cmd_hs_s && !cmd_done) begin
      ocnt_next_s = ocnt_r + OCNT_ONE;
    end else if (!cmd_hs_s && cmd_done) begin
      if (ocnt_r == {OCNT_WIDTH{1'b0}}) begin
        spurious_s = 1'b1;
      end else begin
        ocnt_next_s = ocnt_r - OCNT_ONE;
      end
    end else begin
      ocnt_next_s = ocnt_r;
    end
    throttle_next_s = (ocnt_next_s == OCNT_MAX);
  end

  // Executor FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      n_r             <= {LBA_WIDTH{1'b0}};
      idx_r           <= {LBA_WIDTH{1'b0}};
      ocnt_r          <= {OCNT_WIDTH{1'b0}};
      instr_ready_r   <= 1'b1;
      cmd_valid_r     <= 1'b0;
      cmd_op_r        <= 2'd0;
      cmd_lba_r       <= {LBA_WIDTH{1'b0}};
      cmd_node_idx_r  <= {DATA_NODE_IDX_WIDTH{1'b0}};
      cmd_hash_r      <= {HASH_WIDTH{1'b0}};
      cmd_ref_count_r <= {LBA_WIDTH{1'b0}};
      cmd_last_r      <= 1'b0;
      rsp_valid_r     <= 1'b0;
      rsp_node_idx_r  <= {NODE_IDX_WIDTH{1'b0}};
      rsp_op_r        <= 2'd0;
      rsp_status_r    <= 2'd0;
      rsp_count_r     <= {LBA_WIDTH{1'b0}};
      err_spurious_r  <= 1'b0;
    end else begin
      ocnt_r <= ocnt_next_s;
      if (spurious_s) begin
        err_spurious_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            instr_ready_r  <= 1'b0;
            rsp_node_idx_r <= instr_s.node_idx;
            rsp_op_r       <= instr_s.op_code;
            if (is_data_s && len_zero_s) begin
              rsp_status_r <= ST_EMPTY;
              rsp_count_r  <= {LBA_WIDTH{1'b0}};
              rsp_valid_r  <= 1'b1;
              state_r      <= S_RESP;
            end else if (is_data_s && range_err_s) begin
              rsp_status_r <= ST_RANGE;
              rsp_count_r  <= {LBA_WIDTH{1'b0}};
              rsp_valid_r  <= 1'b1;
              state_r      <= S_RESP;
            end else begin
              n_r             <= is_data_s ? instr_s.ssd_len : LBA_ONE;
              idx_r           <= {LBA_WIDTH{1'b0}};
              cmd_op_r        <= instr_s.op_code;
              cmd_lba_r       <= instr_s.ssd_start;
              cmd_node_idx_r  <= instr_s.ssd_node_idx;
              cmd_hash_r      <= instr_s.sha3_hash;
              cmd_ref_count_r <= instr_s.ref_count;
              cmd_last_r      <= is_data_s ? (instr_s.ssd_len == LBA_ONE) : 1'b1;
              cmd_valid_r     <= 1'b1;
              state_r         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (cmd_hs_s) begin
            if (cmd_last_r) begin
              cmd_valid_r <= 1'b0;
              state_r     <= S_DRAIN;
            end else begin
              idx_r       <= idx_inc_s;
              cmd_lba_r   <= cmd_lba_r + LBA_ONE;
              cmd_last_r  <= last_next_s;
              cmd_valid_r <= !throttle_next_s;
            end
          end else if (!cmd_valid_r) begin
            // Throttled: resume once the registered count has dropped below the limit
            cmd_valid_r <= !throttle_next_s;
          end else begin
            cmd_valid_r <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (ocnt_next_s == {OCNT_WIDTH{1'b0}}) begin
            rsp_status_r <= ST_OK;
            rsp_count_r  <= n_r;
            rsp_valid_r  <= 1'b1;
            state_r      <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r   <= 1'b0;
            instr_ready_r <= 1'b1;
            state_r       <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
